// File: rtl/execute_cycle_if.sv
// ID/EX inputs and EX/MEM outputs of the RISC-V execute stage, bundled as one interface.
// master = decode/hazard side driving the E-stage; slave = execute_cycle.
interface execute_cycle_if #(
  parameter int XLEN = 32
);
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [4:0]      RD_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [XLEN-1:0] ResultW;
  logic [1:0]      ForwardA_E;
  logic [1:0]      ForwardB_E;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM;
  logic            MemWriteM;
  logic            ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] PCPlus4M;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] ALU_ResultM;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    output RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
    output ForwardA_E, ForwardB_E,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
    input  PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    input  RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
    input  ForwardA_E, ForwardB_E,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
    output PCPlus4M, WriteDataM, ALU_ResultM
  );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// Define EXECUTE_FORWARD_EN to enable the MEM/WB forward muxes; otherwise operands come from the register file.
module execute_cycle #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  execute_cycle_if.slave bus
);

  logic [XLEN-1:0] src_a_s;
  logic [XLEN-1:0] fwd_b_s;
  logic [XLEN-1:0] src_b_s;
  logic [XLEN-1:0] alu_result_s;
  logic            zero_s;
  logic            slt_s;

  logic            reg_write_d,  reg_write_q;
  logic            mem_write_d,  mem_write_q;
  logic            result_src_d, result_src_q;
  logic [4:0]      rd_d,         rd_q;
  logic [XLEN-1:0] pc_plus4_d,   pc_plus4_q;
  logic [XLEN-1:0] write_data_d, write_data_q;
  logic [XLEN-1:0] alu_result_d, alu_result_q;

`ifdef EXECUTE_FORWARD_EN
  // Forward mux A: 10 takes last cycle's ALU result so dependent ops need no bubble.
  always_comb begin
    src_a_s = bus.RD1_E;
    case (bus.ForwardA_E)
      2'b01:   src_a_s = bus.ResultW;
      2'b10:   src_a_s = alu_result_q;
      default: src_a_s = bus.RD1_E;
    endcase
  end

  // Forward mux B, independent of mux A.
  always_comb begin
    fwd_b_s = bus.RD2_E;
    case (bus.ForwardB_E)
      2'b01:   fwd_b_s = bus.ResultW;
      2'b10:   fwd_b_s = alu_result_q;
      default: fwd_b_s = bus.RD2_E;
    endcase
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{bus.ForwardA_E, bus.ForwardB_E, bus.ResultW};
  assign src_a_s      = bus.RD1_E;
  assign fwd_b_s      = bus.RD2_E;
`endif

  assign src_b_s = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b_s;
  assign slt_s   = ($signed(src_a_s) < $signed(src_b_s)) ? 1'b1 : 1'b0;

  // ALU; unassigned opcodes yield zero.
  always_comb begin
    alu_result_s = {XLEN{1'b0}};
    case (bus.ALUControlE)
      3'b000:  alu_result_s = src_a_s + src_b_s;
      3'b001:  alu_result_s = src_a_s - src_b_s;
      3'b010:  alu_result_s = src_a_s & src_b_s;
      3'b011:  alu_result_s = src_a_s | src_b_s;
      3'b101:  alu_result_s = {{(XLEN-1){1'b0}}, slt_s};
      default: alu_result_s = {XLEN{1'b0}};
    endcase
  end

  assign zero_s        = (alu_result_s == {XLEN{1'b0}});
  assign bus.PCSrcE    = bus.BranchE & zero_s;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Store data is the forwarded B operand, never the immediate.
  assign reg_write_d  = bus.RegWriteE;
  assign mem_write_d  = bus.MemWriteE;
  assign result_src_d = bus.ResultSrcE;
  assign rd_d         = bus.RD_E;
  assign pc_plus4_d   = bus.PCPlus4E;
  assign write_data_d = fwd_b_s;
  assign alu_result_d = alu_result_s;

  // EX/MEM pipeline register, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'd0;
      pc_plus4_q   <= {XLEN{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      alu_result_q <= {XLEN{1'b0}};
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      write_data_q <= write_data_d;
      alu_result_q <= alu_result_d;
    end
  end

  assign bus.RegWriteM   = reg_write_q;
  assign bus.MemWriteM   = mem_write_q;
  assign bus.ResultSrcM  = result_src_q;
  assign bus.RD_M        = rd_q;
  assign bus.PCPlus4M    = pc_plus4_q;
  assign bus.WriteDataM  = write_data_q;
  assign bus.ALU_ResultM = alu_result_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle; expectations follow EXECUTE_FORWARD_EN when it is defined.
module tb_execute_cycle;

`ifdef EXECUTE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  execute_cycle_if #(.XLEN(32)) bus ();

  execute_cycle #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regwrite"},  {31'd0, bus.RegWriteM},  32'd0);
    chk({tag, "_memwrite"},  {31'd0, bus.MemWriteM},  32'd0);
    chk({tag, "_resultsrc"}, {31'd0, bus.ResultSrcM}, 32'd0);
    chk({tag, "_rd"},        {27'd0, bus.RD_M},       32'd0);
    chk({tag, "_pcplus4"},   bus.PCPlus4M,            32'd0);
    chk({tag, "_wdata"},     bus.WriteDataM,          32'd0);
    chk({tag, "_alu"},       bus.ALU_ResultM,         32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.RegWriteE = 1'b0; bus.ALUSrcE = 1'b0; bus.MemWriteE = 1'b0;
    bus.ResultSrcE = 1'b0; bus.BranchE = 1'b0; bus.ALUControlE = 3'b000;
    bus.RD1_E = 32'd0; bus.RD2_E = 32'd0; bus.Imm_Ext_E = 32'd0; bus.RD_E = 5'd0;
    bus.PCE = 32'd0; bus.PCPlus4E = 32'd0; bus.ResultW = 32'd0;
    bus.ForwardA_E = 2'b00; bus.ForwardB_E = 2'b00;

    repeat (2) tick();
    chk_all_zero("reset");

    // First capture after release: 5 + 7
    bus.RD1_E = 32'd5; bus.RD2_E = 32'd7; bus.RD_E = 5'd3; bus.RegWriteE = 1'b1;
    bus.PCPlus4E = 32'h0000_0008; bus.ResultSrcE = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("add_alu", bus.ALU_ResultM, 32'd12);
    chk("add_rd", {27'd0, bus.RD_M}, 32'd3);
    chk("add_regwrite", {31'd0, bus.RegWriteM}, 32'd1);
    chk("add_resultsrc", {31'd0, bus.ResultSrcM}, 32'd1);
    chk("add_pcplus4", bus.PCPlus4M, 32'h0000_0008);
    chk("add_wdata", bus.WriteDataM, 32'd7);

    // slt -1 < 1, then sub
    bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1; bus.ALUControlE = 3'b101;
    bus.ResultSrcE = 1'b0;
    tick();
    chk("slt_neg", bus.ALU_ResultM, 32'd1);
    bus.ALUControlE = 3'b001;
    tick();
    chk("sub", bus.ALU_ResultM, 32'hFFFF_FFFE);
    bus.ALUControlE = 3'b000;
    tick();
    chk("add_wrap", bus.ALU_ResultM, 32'd0);
    bus.RD1_E = 32'd1; bus.RD2_E = 32'hFFFF_FFFF; bus.ALUControlE = 3'b101;
    tick();
    chk("slt_false", bus.ALU_ResultM, 32'd0);
    bus.RD1_E = 32'hF0F0_1234; bus.RD2_E = 32'h0FF0_FF00; bus.ALUControlE = 3'b010;
    tick();
    chk("and", bus.ALU_ResultM, 32'h00F0_1200);
    bus.ALUControlE = 3'b011;
    tick();
    chk("or", bus.ALU_ResultM, 32'hFFF0_FF34);
    bus.ALUControlE = 3'b110;
    tick();
    chk("op110_zero", bus.ALU_ResultM, 32'd0);

    // beq resolution is combinational
    bus.BranchE = 1'b1; bus.RD1_E = 32'd9; bus.RD2_E = 32'd9; bus.ALUControlE = 3'b001;
    bus.PCE = 32'h0000_0100; bus.Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    chk("br_taken", {31'd0, bus.PCSrcE}, 32'd1);
    chk("br_target", bus.PCTargetE, 32'h0000_00F8);
    bus.RD2_E = 32'd8;
    #1;
    chk("br_not_taken", {31'd0, bus.PCSrcE}, 32'd0);
    bus.RD2_E = 32'd9; bus.BranchE = 1'b0;
    #1;
    chk("br_disabled", {31'd0, bus.PCSrcE}, 32'd0);
    chk("target_no_branch", bus.PCTargetE, 32'h0000_00F8);

    // Forwarding chain
    tick();
    bus.ALUControlE = 3'b000; bus.RD1_E = 32'd2; bus.RD2_E = 32'd3;
    tick();
    chk("fwd_setup", bus.ALU_ResultM, 32'd5);
    bus.ForwardA_E = 2'b10; bus.RD1_E = 32'd100; bus.RD2_E = 32'd4;
    tick();
    chk("fwdA_mem", bus.ALU_ResultM, FWD ? 32'd9 : 32'd104);
    bus.ForwardA_E = 2'b00; bus.ForwardB_E = 2'b01; bus.ResultW = 32'd20;
    bus.RD1_E = 32'd1; bus.RD2_E = 32'd50;
    tick();
    chk("fwdB_wb", bus.ALU_ResultM, FWD ? 32'd21 : 32'd51);
    chk("fwdB_wdata", bus.WriteDataM, FWD ? 32'd20 : 32'd50);
    bus.ForwardA_E = 2'b10; bus.ForwardB_E = 2'b01; bus.RD1_E = 32'd7; bus.RD2_E = 32'd8;
    tick();
    chk("fwd_mixed", bus.ALU_ResultM, FWD ? 32'd41 : 32'd15);
    bus.ForwardA_E = 2'b11; bus.ForwardB_E = 2'b00; bus.ResultW = 32'd1000;
    bus.RD1_E = 32'd3; bus.RD2_E = 32'd4;
    tick();
    chk("fwd_sel11", bus.ALU_ResultM, 32'd7);

    // Store data ignores the immediate
    bus.ForwardA_E = 2'b00; bus.ALUSrcE = 1'b1; bus.Imm_Ext_E = 32'd16;
    bus.RD1_E = 32'h0000_1000; bus.RD2_E = 32'h0000_DEAD; bus.MemWriteE = 1'b1;
    bus.PCPlus4E = 32'h0000_0104; bus.RD_E = 5'd31;
    tick();
    chk("st_alu", bus.ALU_ResultM, 32'h0000_1010);
    chk("st_wdata", bus.WriteDataM, 32'h0000_DEAD);
    chk("st_memwrite", {31'd0, bus.MemWriteM}, 32'd1);
    chk("st_rd", {27'd0, bus.RD_M}, 32'd31);

    // Asynchronous reset mid-operation
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_alu", bus.ALU_ResultM, 32'h0000_1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
